fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the 5-stage RV32 pipeline. It replaces the bare PC register, +4 adder and PC mux with three pieces:
- a BTB with 2-bit saturating counters, giving next-PC prediction;
- a fetch queue that decouples fetch from decode stalls;
- a flush/redirect path driven from EX.
It sits between instruction memory and the IF/ID boundary.

---
 rtl/fetch_pkg.sv | 30 +++
 rtl/fetch_if.sv | 17 +
 rtl/fetch_btb.sv | 48 ++++
 rtl/fetch_unit.sv | 90 +++++++++
 tb/tb_fetch_unit.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the fetch front end: queue entries, BTB entries, 2-bit counter states.
// Fields are sized to the widest supported PC/instruction; modules use the low bits.
package fetch_pkg;
  localparam int PC_MAX  = 32;
  localparam int INS_MAX = 32;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef struct packed {
    logic [PC_MAX-1:0]  pc;
    logic [INS_MAX-1:0] instr;
    logic               pred_taken;
    logic [PC_MAX-1:0]  pred_target;
  } fq_entry_t;

  typedef struct packed {
    logic              valid;
    logic [PC_MAX-1:0] tag;
    logic [1:0]        ctr;
    logic [PC_MAX-1:0] target;
  } btb_entry_t;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction
endpackage

// File: rtl/fetch_if.sv
// IF/ID boundary handshake: fetch queue head presented to decode.
interface fetch_if #(
  parameter int PC_W  = 9,
  parameter int INS_W = 32
);
  logic             id_valid;
  logic             id_ready;
  logic [INS_W-1:0] id_instr;
  logic [PC_W-1:0]  id_pc;
  logic             id_pred_taken;
  logic [PC_W-1:0]  id_pred_target;

  modport master (output id_valid, id_instr, id_pc, id_pred_taken, id_pred_target,
                  input  id_ready);
  modport slave  (input  id_valid, id_instr, id_pc, id_pred_taken, id_pred_target,
                  output id_ready);
endinterface

// File: rtl/fetch_btb.sv
// Direct-mapped BTB with 2-bit saturating counters; combinational lookup, clocked update.
module fetch_btb import fetch_pkg::*; #(
  parameter int PC_W        = 9,
  parameter int BTB_ENTRIES = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_next,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target
);
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  btb_entry_t       tbl [BTB_ENTRIES];
  logic [IDX_W-1:0] lidx, uidx;
  logic [TAG_W-1:0] ltag, utag;
  logic             lhit, uhit;

  assign lidx = lookup_pc[IDX_W+1:2];
  assign ltag = lookup_pc[PC_W-1:IDX_W+2];
  assign uidx = upd_pc[IDX_W+1:2];
  assign utag = upd_pc[PC_W-1:IDX_W+2];

  assign lhit       = tbl[lidx].valid && (tbl[lidx].tag == PC_MAX'(ltag));
  assign uhit       = tbl[uidx].valid && (tbl[uidx].tag == PC_MAX'(utag));
  assign pred_taken = lhit && tbl[lidx].ctr[1];
  assign pred_next  = pred_taken ? tbl[lidx].target[PC_W-1:0] : lookup_pc + PC_W'(4);

  // Not-taken resolutions never allocate, so cold branches stay predicted fall-through.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) tbl[i].valid <= 1'b0;
    end else if (upd_valid) begin
      if (uhit) begin
        tbl[uidx].ctr <= ctr_next(tbl[uidx].ctr, upd_taken);
        if (upd_taken) tbl[uidx].target <= PC_MAX'(upd_target);
      end else if (upd_taken) begin
        tbl[uidx] <= '{valid: 1'b1, tag: PC_MAX'(utag), ctr: CTR_WT,
                       target: PC_MAX'(upd_target)};
      end
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, optional BTB (FETCH_BTB_EN), fetch queue, EX redirect.
// Without FETCH_BTB_EN fetch is strictly sequential and ex_upd_* are ignored.
module fetch_unit import fetch_pkg::*; #(
  parameter int              PC_W        = 9,
  parameter int              INS_W       = 32,
  parameter int              BTB_ENTRIES = 8,
  parameter int              FQ_DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC    = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [INS_W-1:0] imem_rdata,
  fetch_if.master          id,
  input  logic             ex_redirect,
  input  logic [PC_W-1:0]  ex_redirect_pc,
  input  logic             ex_upd_valid,
  input  logic [PC_W-1:0]  ex_upd_pc,
  input  logic             ex_upd_taken,
  input  logic [PC_W-1:0]  ex_upd_target
);
  localparam int PTR_W = $clog2(FQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  pc, pred_next;
  logic             pred_taken;
  fq_entry_t        fq [FQ_DEPTH];
  fq_entry_t        head_e;
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic             push, pop;

`ifdef FETCH_BTB_EN
  fetch_btb #(.PC_W(PC_W), .BTB_ENTRIES(BTB_ENTRIES)) u_btb (
    .clk        (clk),
    .reset      (reset),
    .lookup_pc  (pc),
    .pred_taken (pred_taken),
    .pred_next  (pred_next),
    .upd_valid  (ex_upd_valid),
    .upd_pc     (ex_upd_pc),
    .upd_taken  (ex_upd_taken),
    .upd_target (ex_upd_target)
  );
`else
  logic unused_upd;
  assign unused_upd = ^{ex_upd_valid, ex_upd_pc, ex_upd_taken, ex_upd_target};
  assign pred_taken = 1'b0;
  assign pred_next  = pc + PC_W'(4);
`endif

  assign imem_addr   = pc;
  assign id.id_valid = (count != '0);
  assign pop         = id.id_valid && id.id_ready;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push        = !ex_redirect && ((count < CNT_W'(FQ_DEPTH)) || pop);

  assign head_e            = id.id_valid ? fq[head] : '0;
  assign id.id_pc          = head_e.pc[PC_W-1:0];
  assign id.id_instr       = head_e.instr[INS_W-1:0];
  assign id.id_pred_taken  = head_e.pred_taken;
  assign id.id_pred_target = head_e.pred_target[PC_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else if (ex_redirect) begin
      pc    <= ex_redirect_pc;
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      if (push) begin
        tail <= tail + 1'b1;
        pc   <= pred_next;
      end
      if (pop) head <= head + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push)
      fq[tail] <= '{pc: PC_MAX'(pc), instr: INS_MAX'(imem_rdata),
                    pred_taken: pred_taken, pred_target: PC_MAX'(pred_next)};
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; BTB expectations follow whether FETCH_BTB_EN is defined.
module tb_fetch_unit;
  localparam int PC_W  = 9;
  localparam int INS_W = 32;
`ifdef FETCH_BTB_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [PC_W-1:0]  imem_addr;
  logic [INS_W-1:0] imem_rdata;
  logic             ex_redirect, ex_upd_valid, ex_upd_taken;
  logic [PC_W-1:0]  ex_redirect_pc, ex_upd_pc, ex_upd_target;
  int               passed = 0, failed = 0, total = 0;

  fetch_if #(.PC_W(PC_W), .INS_W(INS_W)) id ();

  assign imem_rdata = 32'h1300_0000 | {23'd0, imem_addr};

  fetch_unit #(.PC_W(PC_W), .INS_W(INS_W), .BTB_ENTRIES(8), .FQ_DEPTH(4), .RESET_PC('0)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .id             (id.master),
    .ex_redirect    (ex_redirect),
    .ex_redirect_pc (ex_redirect_pc),
    .ex_upd_valid   (ex_upd_valid),
    .ex_upd_pc      (ex_upd_pc),
    .ex_upd_taken   (ex_upd_taken),
    .ex_upd_target  (ex_upd_target)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic redirect(input logic [PC_W-1:0] target);
    ex_redirect    = 1'b1;
    ex_redirect_pc = target;
    tick();
    ex_redirect    = 1'b0;
    check("redir_valid", 32'(id.id_valid), 32'd0);
    check("redir_addr", 32'(imem_addr), 32'(target));
  endtask

  task automatic upd(input logic [PC_W-1:0] upc, input logic taken, input logic [PC_W-1:0] tgt);
    ex_upd_valid  = 1'b1;
    ex_upd_pc     = upc;
    ex_upd_taken  = taken;
    ex_upd_target = tgt;
    tick();
    ex_upd_valid  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; id.id_ready = 1'b1;
    ex_redirect = 1'b0; ex_redirect_pc = '0;
    ex_upd_valid = 1'b0; ex_upd_pc = '0; ex_upd_taken = 1'b0; ex_upd_target = '0;
    tick(); tick();
    check("rst_valid", 32'(id.id_valid), 32'd0);
    check("rst_pc", 32'(id.id_pc), 32'd0);
    check("rst_instr", id.id_instr, 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_ptaken", 32'(id.id_pred_taken), 32'd0);

    // Streaming with decode always ready
    reset = 1'b0;
    tick();
    check("first_valid", 32'(id.id_valid), 32'd1);
    check("first_instr", id.id_instr, 32'h1300_0000);
    check("first_addr", 32'(imem_addr), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      check("seq_pc", 32'(id.id_pc), 32'(4 * i));
      check("seq_ptaken", 32'(id.id_pred_taken), 32'd0);
    end

    // Fill under decode stall, then drain in order
    reset = 1'b1; id.id_ready = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("full_addr", 32'(imem_addr), 32'd16);
    check("full_valid", 32'(id.id_valid), 32'd1);
    check("full_head", 32'(id.id_pc), 32'd0);
    id.id_ready = 1'b1;
    tick();
    check("drain_addr", 32'(imem_addr), 32'd20);
    check("drain_pc", 32'(id.id_pc), 32'd4);
    for (int i = 2; i <= 4; i++) begin
      tick();
      check("drain_pc", 32'(id.id_pc), 32'(4 * i));
    end
    check("drain_addr_end", 32'(imem_addr), 32'd32);
    id.id_ready = 1'b0;
    tick();
    check("hold_addr", 32'(imem_addr), 32'd32);
    check("hold_head", 32'(id.id_pc), 32'd16);

    // Redirect while full
    redirect(9'h040);
    check("flush_pc", 32'(id.id_pc), 32'd0);
    tick();
    check("redir_head", 32'(id.id_pc), 32'h40);
    check("redir_instr", id.id_instr, 32'h1300_0040);
    check("redir_next", 32'(imem_addr), 32'h44);
    id.id_ready = 1'b1;

    // PC wraps modulo 2^PC_W
    redirect(9'h1FC);
    tick();
    check("wrap_pc", 32'(id.id_pc), 32'h1FC);
    check("wrap_addr", 32'(imem_addr), 32'h000);

    // Taken allocation at 0x20 -> 0x08
    upd(9'h020, 1'b1, 9'h008);
    redirect(9'h020);
    tick();
    check("alloc_pc", 32'(id.id_pc), 32'h20);
    check("alloc_ptaken", 32'(id.id_pred_taken), 32'(BTB));
    check("alloc_ptgt", 32'(id.id_pred_target), BTB ? 32'h08 : 32'h24);
    tick();
    check("alloc_follow", 32'(id.id_pc), BTB ? 32'h08 : 32'h24);

    // Four not-taken saturate at 00; one taken then reaches only 01
    for (int i = 0; i < 4; i++) upd(9'h020, 1'b0, 9'h000);
    upd(9'h020, 1'b1, 9'h008);
    redirect(9'h020);
    tick();
    check("sat_ptaken", 32'(id.id_pred_taken), 32'd0);
    check("sat_ptgt", 32'(id.id_pred_target), 32'h24);
    upd(9'h020, 1'b1, 9'h008);
    redirect(9'h020);
    tick();
    check("retrain_ptaken", 32'(id.id_pred_taken), 32'(BTB));
    check("retrain_ptgt", 32'(id.id_pred_target), BTB ? 32'h08 : 32'h24);

    // Not-taken on a miss never allocates
    upd(9'h030, 1'b0, 9'h100);
    redirect(9'h030);
    tick();
    check("nt_miss_ptaken", 32'(id.id_pred_taken), 32'd0);
    check("nt_miss_ptgt", 32'(id.id_pred_target), 32'h34);

    // Redirect and update in the same cycle
    ex_upd_valid = 1'b1; ex_upd_pc = 9'h050; ex_upd_taken = 1'b1; ex_upd_target = 9'h010;
    redirect(9'h050);
    ex_upd_valid = 1'b0;
    tick();
    check("both_pc", 32'(id.id_pc), 32'h50);
    check("both_ptaken", 32'(id.id_pred_taken), 32'(BTB));
    check("both_ptgt", 32'(id.id_pred_target), BTB ? 32'h10 : 32'h54);
    tick();
    check("both_follow", 32'(id.id_pc), BTB ? 32'h10 : 32'h54);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
